// File: rtl/updown_shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_shift_counter
// Description : Parametrised loadable up/down counter and bidirectional shift
//               register with a combinational terminal-count carry, a
//               combinational serial output and an independent serial
//               pattern detector on the serial input.
// Optional    : COUNTER_AUTORELOAD_EN - when defined, the counter reloads the
//               last parallel-load value instead of wrapping at its terminal
//               count (up or down). When undefined no reload register exists.
// Ports       : i_clk     rising-edge clock
//               i_rst_n   asynchronous active-low reset
//               i_sload   synchronous parallel load (highest priority)
//               i_enable  count/shift enable
//               i_mode    00 down, 01 up, 10 shift right, 11 shift left
//               i_data    parallel load value [WIDTH]
//               i_serin   serial input (shifter and detector)
//               o_qout    register contents [WIDTH]
//               o_serout  serial output (combinational)
//               o_co      terminal-count carry (combinational)
//               o_det     registered one-cycle pattern-detect pulse
// Revision    : 1.0 - initial release
// ============================================================================
module updown_shift_counter #(
    parameter int              WIDTH   = 8,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sload,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_serin,
    output logic [WIDTH-1:0] o_qout,
    output logic             o_serout,
    output logic             o_co,
    output logic             o_det
);

    localparam logic [1:0] c_MODE_DOWN  = 2'b00;
    localparam logic [1:0] c_MODE_UP    = 2'b01;
    localparam logic [1:0] c_MODE_SHR   = 2'b10;
    localparam logic [1:0] c_MODE_SHL   = 2'b11;

    localparam int               c_FILL_W    = $clog2(PLEN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PLEN);
    // The incoming bit completes the window, so PLEN-1 earlier samples suffice.
    localparam logic [c_FILL_W-1:0] c_FILL_ARM  = c_FILL_W'(PLEN - 1);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    // ------------------------------------------------------------------------
    // Counter / shifter datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_qout;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_zero;
    logic             w_at_ones;
    logic             w_terminal;
    logic             w_ser;

    assign w_at_zero = (r_qout == c_ZERO);
    assign w_at_ones = (r_qout == c_ONES);

`ifdef COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reload <= c_ZERO;
        end else if (i_sload) begin
            r_reload <= i_data;
        end
    end
`endif

    always_comb begin
        w_q_next = r_qout;
        if (i_sload) begin
            w_q_next = i_data;
        end else if (i_enable) begin
            case (i_mode)
                c_MODE_DOWN: begin
`ifdef COUNTER_AUTORELOAD_EN
                    if (w_at_zero) begin
                        w_q_next = r_reload;
                    end else begin
                        w_q_next = r_qout - c_ONE;
                    end
`else
                    w_q_next = r_qout - c_ONE;
`endif
                end
                c_MODE_UP: begin
`ifdef COUNTER_AUTORELOAD_EN
                    if (w_at_ones) begin
                        w_q_next = r_reload;
                    end else begin
                        w_q_next = r_qout + c_ONE;
                    end
`else
                    w_q_next = r_qout + c_ONE;
`endif
                end
                c_MODE_SHR: w_q_next = {i_serin, r_qout[WIDTH-1:1]};
                default:    w_q_next = {r_qout[WIDTH-2:0], i_serin};
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qout <= c_ZERO;
        end else begin
            r_qout <= w_q_next;
        end
    end

    always_comb begin
        w_terminal = 1'b0;
        w_ser      = 1'b0;
        case (i_mode)
            c_MODE_DOWN: w_terminal = w_at_zero;
            c_MODE_UP:   w_terminal = w_at_ones;
            c_MODE_SHR:  w_ser      = r_qout[0];
            c_MODE_SHL:  w_ser      = r_qout[WIDTH-1];
            default: begin
                w_terminal = 1'b0;
                w_ser      = 1'b0;
            end
        endcase
    end

    // Both outputs are combinational; gating with the reset keeps them low
    // while reset is held even though mode/enable inputs may be active.
    assign o_co     = i_rst_n & i_enable & ~i_sload & w_terminal;
    assign o_serout = i_rst_n & w_ser;
    assign o_qout   = r_qout;

    // ------------------------------------------------------------------------
    // Serial pattern detector (independent of load/enable/mode)
    // ------------------------------------------------------------------------
    logic [PLEN-1:0]     r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_det;
    logic [PLEN:0]       w_window;
    logic                w_match;
    logic                w_unused_oldest;

    // Newest bit at the LSB; the low PLEN bits are the candidate match with
    // the oldest pattern bit in the MSB position.
    assign w_window        = {r_hist, i_serin};
    assign w_match         = (w_window[PLEN-1:0] == PATTERN) && (r_fill >= c_FILL_ARM);
    // The oldest stored bit ages out without ever being compared.
    assign w_unused_oldest = w_window[PLEN];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_det  <= 1'b0;
        end else begin
            r_hist <= w_window[PLEN-1:0];
            r_det  <= w_match;
            if (r_fill != c_FILL_FULL) begin
                r_fill <= r_fill + c_FILL_W'(1);
            end
        end
    end

    assign o_det = r_det;

endmodule
`default_nettype wire

// File: tb/tb_updown_shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_shift_counter
// Description : Self-checking bench for updown_shift_counter (WIDTH=8,
//               PLEN=4, PATTERN=1011). A behavioural model predicts qout/det
//               per edge into a scoreboard queue; co/serout are checked before
//               each edge. Directed constant checks cover the listed scenarios.
//               Honours COUNTER_AUTORELOAD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_shift_counter;

    localparam int              WIDTH   = 8;
    localparam int              PLEN    = 4;
    localparam logic [PLEN-1:0] PATTERN = 4'b1011;

`ifdef COUNTER_AUTORELOAD_EN
    localparam bit c_AR = 1'b1;
`else
    localparam bit c_AR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sload = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] data = '0;
    logic             serin = 1'b0;
    logic [WIDTH-1:0] qout;
    logic             serout;
    logic             co;
    logic             det;

    updown_shift_counter #(
        .WIDTH   (WIDTH),
        .PLEN    (PLEN),
        .PATTERN (PATTERN)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sload  (sload),
        .i_enable (enable),
        .i_mode   (mode),
        .i_data   (data),
        .i_serin  (serin),
        .o_qout   (qout),
        .o_serout (serout),
        .o_co     (co),
        .o_det    (det)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             d;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_reload;
    logic [PLEN-1:0]  m_hist;
    int               m_fill;
    logic             m_prev_det;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q        = '0;
        m_reload   = '0;
        m_hist     = '0;
        m_fill     = 0;
        m_prev_det = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, predict the
    // edge result into the scoreboard, then compare after the edge.
    task automatic tick();
        logic          e_co;
        logic          e_ser;
        logic [PLEN:0] win;
        logic          nd;
        exp_t          e;
        exp_t          got;
        #2;
        e_co  = enable && !sload &&
                ((mode == 2'b00 && m_q == '0) || (mode == 2'b01 && m_q == '1));
        e_ser = (mode == 2'b10) ? m_q[0] : (mode == 2'b11) ? m_q[WIDTH-1] : 1'b0;
        check("co", 32'(co), 32'(e_co));
        check("serout", 32'(serout), 32'(e_ser));

        win = {m_hist, serin};
        nd  = (win[PLEN-1:0] == PATTERN) && (m_fill >= PLEN - 1);
        m_hist = win[PLEN-1:0];
        if (m_fill < PLEN) m_fill++;
        if (sload) begin
            m_q      = data;
            m_reload = data;
        end else if (enable) begin
            case (mode)
                2'b00: m_q = (c_AR && m_q == '0) ? m_reload : m_q - 8'd1;
                2'b01: m_q = (c_AR && m_q == '1) ? m_reload : m_q + 8'd1;
                2'b10: m_q = {serin, m_q[WIDTH-1:1]};
                default: m_q = {m_q[WIDTH-2:0], serin};
            endcase
        end
        e.q = m_q;
        e.d = nd;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("qout", 32'(qout), 32'(got.q));
            check("det", 32'(det), 32'(got.d));
            if (m_prev_det) check("det_double", 32'(det), 32'd0);
            m_prev_det = det;
        end
    endtask

    logic [WIDTH-1:0] exp_dn [4];
    logic [WIDTH-1:0] exp_up [2];
    logic [WIDTH-1:0] exp_shr[4];
    logic             stream [7];
    logic             exp_det[7];

    initial begin
        exp_dn  = '{8'h02, 8'h01, 8'h00, (c_AR ? 8'h03 : 8'hFF)};
        exp_up  = '{8'hFF, (c_AR ? 8'hFE : 8'h00)};
        exp_shr = '{8'hD8, 8'hEC, 8'hF6, 8'hFB};
        stream  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_det = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();

        // Reset state with inputs that would otherwise raise co
        enable = 1'b1;
        mode   = 2'b00;
        #12;
        check("rst_qout", 32'(qout), 32'd0);
        check("rst_det", 32'(det), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_serout", 32'(serout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load 03 then count down
        sload = 1'b1; enable = 1'b0; data = 8'h03;
        tick();
        check("load03", 32'(qout), 32'h03);
        sload = 1'b0; enable = 1'b1; mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (qout == 8'h00) check("co_at_00", 32'(co), 32'd1);
            tick();
            check("down_seq", 32'(qout), 32'(exp_dn[i]));
        end

        // Load FE then count up
        sload = 1'b1; data = 8'hFE;
        tick();
        sload = 1'b0; mode = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("up_seq", 32'(qout), 32'(exp_up[i]));
        end

        // Load B0, shift right with serin=1, then shift left with serin=0
        sload = 1'b1; data = 8'hB0;
        tick();
        sload = 1'b0; mode = 2'b10; serin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("shr_seq", 32'(qout), 32'(exp_shr[i]));
        end
        mode = 2'b11; serin = 1'b0;
        #2;
        check("shl_serout", 32'(serout), 32'd1);
        tick();
        check("shl_q", 32'(qout), 32'hF6);

        // Load and enable together in count-down mode
        sload = 1'b1; enable = 1'b1; mode = 2'b00; data = 8'h55;
        #2;
        check("load_en_co", 32'(co), 32'd0);
        tick();
        check("load_en_q", 32'(qout), 32'h55);

        // Load 42, partially match the pattern, then reset between edges
        data = 8'h42;
        tick();
        sload = 1'b0; enable = 1'b0;
        serin = 1'b1; tick();
        serin = 1'b0; tick();
        serin = 1'b1; tick();
        check("pre_rst_q", 32'(qout), 32'h42);
        enable = 1'b1; mode = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_qout", 32'(qout), 32'd0);
        check("async_det", 32'(det), 32'd0);
        check("async_co", 32'(co), 32'd0);
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b0;

        // Overlapping detection from a fresh history
        for (int i = 0; i < 7; i++) begin
            serin = stream[i];
            tick();
            check("det_seq", 32'(det), 32'(exp_det[i]));
        end
        serin = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
